// File: rtl/pe_acc_requant_drain.sv
// Captures one column of PE accumulators and drains them one per cycle through a
// two-stage requantization pipeline (multiply, then round/ReLU/zero-point/saturate).
module pe_acc_requant_drain #(
    parameter int unsigned N    = 4,
    parameter int unsigned ACCW = 32,
    parameter int unsigned MW   = 16,
    parameter int unsigned OW   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MW-1:0]          cfg_mult,
    input  logic [5:0]             cfg_shift,
    input  logic [OW-1:0]          cfg_zp,
    input  logic                   cfg_relu,
    input  logic                   cap_valid,
    output logic                   cap_ready,
    input  logic [N*ACCW-1:0]      cap_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OW-1:0]          out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned PW    = ACCW + MW;
    localparam int unsigned EW    = PW + 1;
    localparam int unsigned MaxSh = PW - 2;

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic signed [ACCW-1:0] acc_q [N];
    logic signed [MW-1:0]   mult_q;
    logic [5:0]             shift_q;
    logic signed [OW-1:0]   zp_q;
    logic                   relu_q;

    logic signed [PW-1:0]   s1_q, s1_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [IW-1:0]          s1_idx_q, s1_idx_d;
    logic                   s1_last_q, s1_last_d;

    logic                   out_valid_q;
    logic [OW-1:0]          out_data_q;
    logic [IW-1:0]          out_idx_q;
    logic                   out_last_q;

    logic                   advance;
    logic                   cap_fire;
    logic signed [PW-1:0]   a_ext, m_ext, prod;

    logic [5:0]             sh;
    logic signed [EW-1:0]   p_ext, rnd, r, v;
    logic                   fits;
    logic [OW-1:0]          sat;

    assign advance   = !out_valid_q || out_ready;
    assign cap_ready = (state_q == StIdle);
    assign cap_fire  = cap_valid && cap_ready;
    assign busy      = (state_q == StDrain) || s1_valid_q || out_valid_q;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

    // Stage 1 operand: operands sign-extended to full product width
    always_comb begin
        a_ext = PW'(acc_q[idx_q]);
        m_ext = PW'(mult_q);
        prod  = a_ext * m_ext;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s1_idx_d   = s1_idx_q;
        s1_last_d  = s1_last_q;
        unique case (state_q)
            StIdle: begin
                if (advance) begin
                    s1_valid_d = 1'b0;
                end
                if (cap_fire) begin
                    state_d = StDrain;
                    idx_d   = '0;
                end
            end
            StDrain: begin
                if (advance) begin
                    s1_d       = prod;
                    s1_valid_d = 1'b1;
                    s1_idx_d   = idx_q;
                    s1_last_d  = (idx_q == IW'(N - 1));
                    if (idx_q == IW'(N - 1)) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage 2: one extra bit of headroom so the rounding add cannot overflow
    always_comb begin
        sh    = (shift_q > 6'(MaxSh)) ? 6'(MaxSh) : shift_q;
        p_ext = {s1_q[PW-1], s1_q};
        rnd   = (sh != 6'd0) ? (EW'(1) << (sh - 6'd1)) : '0;
        r     = (p_ext + rnd) >>> sh;
        if (relu_q && r[EW-1]) begin
            r = '0;
        end
        v    = r + {{(EW - OW){zp_q[OW-1]}}, zp_q};
        fits = (&v[EW-1:OW-1]) || !(|v[EW-1:OW-1]);
        if (fits) begin
            sat = v[OW-1:0];
        end else if (v[EW-1]) begin
            sat = {1'b1, {(OW - 1){1'b0}}};
        end else begin
            sat = {1'b0, {(OW - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            mult_q      <= '0;
            shift_q     <= '0;
            zp_q        <= '0;
            relu_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_last_q  <= s1_last_d;
            if (advance) begin
                out_valid_q <= s1_valid_q;
                out_data_q  <= sat;
                out_idx_q   <= s1_idx_q;
                out_last_q  <= s1_valid_q && s1_last_q;
            end
            if (cap_fire) begin
                mult_q  <= cfg_mult;
                shift_q <= cfg_shift;
                zp_q    <= cfg_zp;
                relu_q  <= cfg_relu;
            end
        end
    end

    // Accumulator snapshot needs no reset: it is only read after a capture
    always_ff @(posedge clk) begin
        if (cap_fire && !rst) begin
            for (int i = 0; i < int'(N); i++) begin
                acc_q[i] <= cap_data[i*ACCW +: ACCW];
            end
        end
    end

endmodule
